// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, instruction field positions and sequencer states.
// ALU_SEQ_MULDIV_EN adds the WB_HI state used by mul/div.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_MSB  = 26;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_MSB  = 22;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_MSB  = 18;
    localparam int unsigned RC_LSB  = 15;
    localparam int unsigned C_MSB   = 18;
    localparam int unsigned C_W     = 19;

    typedef enum logic [2:0] {
        StIdle,
        StLoadY,
        StExec,
        StWbLo,
`ifdef ALU_SEQ_MULDIV_EN
        StWbHi,
`endif
        StFault
    } seq_state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier for the ALU sequencer.
// mul/div are only legal when ALU_SEQ_MULDIV_EN is defined.
module alu_seq_decode
    import alu_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             legal,
    output logic             is_imm,
    output logic             is_unary,
    output logic             is_muldiv
);

    always_comb begin
        legal     = 1'b0;
        is_imm    = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: legal = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: begin
                legal  = 1'b1;
                is_imm = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                legal    = 1'b1;
                is_unary = 1'b1;
            end
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_DIV: begin
                legal     = 1'b1;
                is_muldiv = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle strobe sequencer around the bus-based ALU datapath.
// Define ALU_SEQ_MULDIV_EN to enable mul/div with HI/LO writeback.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned OPC_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] ir,
    output logic              ready,
    output logic [REG_AW-1:0] rf_rsel,
    output logic              rf_out,
    output logic              c_out,
    output logic [DATA_W-1:0] c_sext,
    output logic              y_in,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              z_in,
    output logic              zlo_out,
    output logic              zhi_out,
    output logic [REG_AW-1:0] rf_wsel,
    output logic              rf_we,
    output logic              lo_in,
    output logic              hi_in,
    output logic              done,
    output logic              err
);

    seq_state_e        state_q;
    logic [DATA_W-1:0] ir_q;

    logic [OPC_W-1:0]  dec_opc;
    logic              legal, is_imm, is_unary, is_muldiv;
    logic [REG_AW-1:0] ra, rb, rc;

    assign ra = ir_q[RA_MSB:RA_LSB];
    assign rb = ir_q[RB_MSB:RB_LSB];
    assign rc = ir_q[RC_MSB:RC_LSB];
    assign c_sext = {{(DATA_W-C_W){ir_q[C_MSB]}}, ir_q[C_MSB:0]};

    // One classifier: incoming word while idle (accept decision), latched word otherwise.
    assign dec_opc = (state_q == StIdle) ? ir[OPC_MSB:OPC_LSB] : ir_q[OPC_MSB:OPC_LSB];

    alu_seq_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode    (dec_opc),
        .legal     (legal),
        .is_imm    (is_imm),
        .is_unary  (is_unary),
        .is_muldiv (is_muldiv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        ir_q    <= ir;
                        state_q <= legal ? StLoadY : StFault;
                    end
                end
                StLoadY: state_q <= StExec;
                StExec:  state_q <= StWbLo;
`ifdef ALU_SEQ_MULDIV_EN
                StWbLo:  state_q <= is_muldiv ? StWbHi : StIdle;
                StWbHi:  state_q <= StIdle;
`else
                StWbLo:  state_q <= StIdle;
`endif
                StFault: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ready      = 1'b0;
        rf_rsel    = '0;
        rf_out     = 1'b0;
        c_out      = 1'b0;
        y_in       = 1'b0;
        alu_opcode = '0;
        z_in       = 1'b0;
        zlo_out    = 1'b0;
        zhi_out    = 1'b0;
        rf_wsel    = '0;
        rf_we      = 1'b0;
        lo_in      = 1'b0;
        hi_in      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            StIdle: ready = 1'b1;
            StLoadY: begin
                rf_out  = 1'b1;
                y_in    = 1'b1;
                rf_rsel = is_muldiv ? ra : rb;
            end
            StExec: begin
                alu_opcode = ir_q[OPC_MSB:OPC_LSB];
                z_in       = 1'b1;
                if (is_imm) begin
                    c_out = 1'b1;
                end else begin
                    rf_out  = 1'b1;
                    rf_rsel = (is_unary || is_muldiv) ? rb : rc;
                end
            end
            StWbLo: begin
                zlo_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (is_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    rf_we   = 1'b1;
                    rf_wsel = ra;
                    done    = 1'b1;
                end
`else
                rf_we   = 1'b1;
                rf_wsel = ra;
                done    = 1'b1;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            StWbHi: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
`endif
            StFault: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; follows ALU_SEQ_MULDIV_EN if defined.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = '0;

    logic        ready, rf_out, c_out, y_in, z_in, zlo_out, zhi_out;
    logic        rf_we, lo_in, hi_in, done, err;
    logic [3:0]  rf_rsel, rf_wsel;
    logic [4:0]  alu_opcode;
    logic [31:0] c_sext;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ir         (ir),
        .ready      (ready),
        .rf_rsel    (rf_rsel),
        .rf_out     (rf_out),
        .c_out      (c_out),
        .c_sext     (c_sext),
        .y_in       (y_in),
        .alu_opcode (alu_opcode),
        .z_in       (z_in),
        .zlo_out    (zlo_out),
        .zhi_out    (zhi_out),
        .rf_wsel    (rf_wsel),
        .rf_we      (rf_we),
        .lo_in      (lo_in),
        .hi_in      (hi_in),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] RDY = 12'h800, RFO = 12'h400, CO  = 12'h200, YI  = 12'h100;
    localparam logic [11:0] ZI  = 12'h080, ZLO = 12'h040, ZHI = 12'h020, WE  = 12'h010;
    localparam logic [11:0] LOI = 12'h008, HII = 12'h004, DN  = 12'h002, ER  = 12'h001;

    logic [24:0] obs;
    logic [24:0] exp_v;
    assign obs = {ready, rf_out, c_out, y_in, z_in, zlo_out, zhi_out, rf_we, lo_in, hi_in,
                  done, err, rf_rsel, rf_wsel, alu_opcode};

    int n_vec = 0;
    int n_err = 0;

    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        start = 1'b1;
        ir    = w;
        @(negedge clk);
        start = 1'b0;
        ir    = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", obs, exp_v);
        end
        n_vec++;
        if (c_sext !== 32'h0) begin
            n_err++;
            $display("FAIL reset_c_sext: got %h want %h", c_sext, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue({5'b00011, 4'd3, 4'd4, 4'd5, 15'd0});
        exp_v = {RFO | YI, 4'd4, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL add_load_y: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RFO | ZI, 4'd5, 4'd0, 5'b00011};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL add_exec: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {ZLO | WE | DN, 4'd0, 4'd3, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL add_wb_lo: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL add_ready: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_addi();
        issue({5'b01100, 4'd2, 4'd1, 19'h7FFFF});
        exp_v = {RFO | YI, 4'd1, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL addi_load_y: got %h want %h", obs, exp_v);
        end
        n_vec++;
        if (c_sext !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL addi_c_sext: got %h want %h", c_sext, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        exp_v = {CO | ZI, 4'd0, 4'd0, 5'b01100};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL addi_exec: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {ZLO | WE | DN, 4'd0, 4'd2, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL addi_wb_lo: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_unary();
        issue({5'b10001, 4'd8, 4'd9, 4'd0, 15'd0});
        exp_v = {RFO | YI, 4'd9, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL neg_load_y: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RFO | ZI, 4'd9, 4'd0, 5'b10001};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL neg_exec: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {ZLO | WE | DN, 4'd0, 4'd8, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL neg_wb_lo: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_muldiv();
        issue({5'b01111, 4'd6, 4'd7, 19'd0});
`ifdef ALU_SEQ_MULDIV_EN
        exp_v = {RFO | YI, 4'd6, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL mul_load_y: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RFO | ZI, 4'd7, 4'd0, 5'b01111};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL mul_exec: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {ZLO | LOI, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL mul_wb_lo: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {ZHI | HII | DN, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL mul_wb_hi: got %h want %h", obs, exp_v);
        end
`else
        exp_v = {DN | ER, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL mul_fault: got %h want %h", obs, exp_v);
        end
`endif
        @(negedge clk);
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL mul_ready: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_illegal();
        issue({5'b11111, 27'h5A5A5A5});
        exp_v = {DN | ER, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL illegal_fault: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL illegal_ready: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_start_while_busy();
        issue({5'b00100, 4'd1, 4'd2, 4'd3, 15'd0});
        exp_v = {RFO | YI, 4'd2, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL busy_load_y: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RFO | ZI, 4'd3, 4'd0, 5'b00100};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL busy_exec: got %h want %h", obs, exp_v);
        end
        start = 1'b1;
        ir    = {5'b01100, 4'd9, 4'd10, 19'h40000};
        @(negedge clk);
        start = 1'b0;
        exp_v = {ZLO | WE | DN, 4'd0, 4'd1, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL busy_wb_lo: got %h want %h", obs, exp_v);
        end
        n_vec++;
        if (c_sext !== 32'h0001_8000) begin
            n_err++; $display("FAIL busy_c_sext: got %h want %h", c_sext, 32'h0001_8000);
        end
        @(negedge clk);
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL busy_not_queued: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL busy_still_idle: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        issue({5'b00101, 4'd1, 4'd2, 4'd3, 15'd0});
        @(negedge clk);
        @(negedge clk);
        exp_v = {ZLO | WE | DN, 4'd0, 4'd1, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL b2b_first_done: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL b2b_ready: got %h want %h", obs, exp_v);
        end
        start = 1'b1;
        ir    = {5'b00110, 4'd4, 4'd5, 4'd6, 15'd0};
        @(negedge clk);
        start = 1'b0;
        exp_v = {RFO | YI, 4'd5, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL b2b_load_y: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {RFO | ZI, 4'd6, 4'd0, 5'b00110};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL b2b_exec: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {ZLO | WE | DN, 4'd0, 4'd4, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL b2b_wb_lo: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        issue({5'b00011, 4'd3, 4'd4, 4'd5, 15'd0});
        @(negedge clk);
        exp_v = {RFO | ZI, 4'd5, 4'd0, 5'b00011};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL abort_exec: got %h want %h", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {RDY, 4'd0, 4'd0, 5'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL abort_immediate: got %h want %h", obs, exp_v);
        end
        n_vec++;
        if (c_sext !== 32'h0) begin
            n_err++; $display("FAIL abort_c_sext: got %h want %h", c_sext, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL abort_no_wb[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_unary();
        test_muldiv();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
